alu_seq: RTL and testbench

//  Parametrised, registered successor to the 4-bit combinational ALU. Same 3-bit opcode map
//  (ADD/SUB/MUL/DIV/AND/OR/NAND/NOR). Adds full-width MUL product, a remainder output and a

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_seq_muldiv.sv | 103 ++++++++++
 rtl/alu_seq.sv | 150 +++++++++++++++
 tb/tb_alu_seq.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU: the 3-bit opcode map and the
// control FSM state encoding used by alu_seq.
// ----------------------------------------------------------------------------
package alu_pkg;

   // Opcode map, unchanged from the original combinational 4-bit ALU.
   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_MUL  = 3'b010;
   localparam logic [2:0] OP_DIV  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_NAND = 3'b110;
   localparam logic [2:0] OP_NOR  = 3'b111;

   // IDLE: accepting; BUSY: iterative MUL/DIV in flight; DONE: result held.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_seq_muldiv.sv
// ----------------------------------------------------------------------------
// alu_seq_muldiv
// Iterative engine for unsigned multiply (shift-add) and divide (restoring),
// one bit per clock, WIDTH iterations after the start cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load operands (a, b) and operation (is_div), begin iterating
//   is_div     : 1 = divide a by b, 0 = multiply a by b
//   a, b       : unsigned operands
//   done       : high during the final iteration cycle
//   lo, hi     : result of the iteration being completed this cycle
//                (MUL: product low/high half; DIV: quotient/remainder);
//                only meaningful while done is high
// ----------------------------------------------------------------------------
module alu_seq_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   localparam int CW = $clog2(WIDTH);

   logic             run;
   logic             div_q;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] acc;    // MUL: partial-product high half; DIV: partial remainder
   logic [WIDTH-1:0] q;      // MUL: multiplier shifting out / product low half; DIV: dividend -> quotient
   logic [WIDTH-1:0] d;      // multiplicand or divisor

   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] rem_sub;
   logic             fits;
   logic [WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0] q_nxt;

   // One iteration step, evaluated combinationally so the last step's result
   // can be captured by the parent on the same edge that finishes the run.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      acc_nxt = acc;
      q_nxt   = q;
      add_sum = {1'b0, acc} + (q[0] ? {1'b0, d} : '0);
      shifted = {acc, q[WIDTH-1]};
      fits    = (shifted >= {1'b0, d});
      // True difference is < d when it fits, so it always fits in WIDTH bits.
      rem_sub = shifted[WIDTH-1:0] - d;
      if (div_q) begin
         if (fits) begin
            acc_nxt = rem_sub;
            q_nxt   = {q[WIDTH-2:0], 1'b1};
         end else begin
            acc_nxt = shifted[WIDTH-1:0];
            q_nxt   = {q[WIDTH-2:0], 1'b0};
         end
      end else begin
         // {acc,q} shifts right one bit with the adder carry entering at the top.
         acc_nxt = add_sum[WIDTH:1];
         q_nxt   = {add_sum[0], q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: datapath registers are reset as well so a reset mid-run leaves nothing stale behind.
      if (!rst_n) begin
         run   <= 1'b0;
         div_q <= 1'b0;
         cnt   <= '0;
         acc   <= '0;
         q     <= '0;
         d     <= '0;
      end else if (start) begin
         // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
         run   <= 1'b1;
         div_q <= is_div;
         cnt   <= '0;
         acc   <= '0;
         q     <= a;
         d     <= b;
      end else if (run) begin
         acc <= acc_nxt;
         q   <= q_nxt;
         cnt <= cnt + CW'(1);
         if (cnt == CW'(WIDTH - 1)) begin
            run <= 1'b0;
         end
      end
   end

   assign done = run && (cnt == CW'(WIDTH - 1));
   assign lo   = q_nxt;
   assign hi   = acc_nxt;

endmodule

// File: rtl/alu_seq.sv
// ----------------------------------------------------------------------------
// alu_seq
// Registered, handshaked ALU. Single-cycle ops (ADD/SUB/logic, DIV by zero)
// complete one cycle after accept; MUL/DIV run WIDTH cycles in the iterative
// engine. One operation in flight at a time; results held until consumed.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready only in IDLE)
//   A, B, Alu_sel        : unsigned operands and opcode, captured on accept
//   out_valid / out_ready: result handshake
//   Alu_out              : result / MUL low half / DIV quotient
//   Alu_hi               : MUL high half / DIV remainder / 0
//   carry                : ADD carry-out, SUB borrow
//   zero                 : Alu_out == 0
//   ovf                  : MUL high half non-zero
//   div0                 : DIV with B == 0
// ----------------------------------------------------------------------------
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       Alu_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Alu_out,
   output logic [WIDTH-1:0] Alu_hi,
   output logic             carry,
   output logic             zero,
   output logic             ovf,
   output logic             div0
);

   state_t state, state_nxt;

   logic             accept;
   logic             multi;
   logic             mul_q;
   logic             eng_done;
   logic [WIDTH-1:0] eng_lo;
   logic [WIDTH-1:0] eng_hi;

   logic             load;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_hi;
   logic             r_carry;
   logic             r_ovf;
   logic             r_div0;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign accept    = in_valid & in_ready;
   // Division by zero bypasses the engine and completes like a single-cycle op.
   assign multi     = (Alu_sel == OP_MUL) || ((Alu_sel == OP_DIV) && (B != '0));

   alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (accept & multi),
      .is_div (Alu_sel == OP_DIV),
      .a      (A),
      .b      (B),
      .done   (eng_done),
      .lo     (eng_lo),
      .hi     (eng_hi)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept)    state_nxt = multi ? ST_BUSY : ST_DONE;
         ST_BUSY: if (eng_done)  state_nxt = ST_DONE;
         ST_DONE: if (out_ready) state_nxt = ST_IDLE;
         default:                state_nxt = ST_IDLE;
      endcase
   end

   // Result selection; load marks the single edge on which DONE is entered.
   always_comb begin
      load    = 1'b0;
      r_lo    = '0;
      r_hi    = '0;
      r_carry = 1'b0;
      r_ovf   = 1'b0;
      r_div0  = 1'b0;
      sum     = {1'b0, A} + {1'b0, B};
      diff    = {1'b0, A} - {1'b0, B};   // top bit is the borrow when A < B
      if ((state == ST_IDLE) && accept && !multi) begin
         load = 1'b1;
         case (Alu_sel)
            OP_ADD:  {r_carry, r_lo} = sum;
            OP_SUB:  {r_carry, r_lo} = diff;
            OP_DIV: begin
               r_hi   = A;
               r_div0 = 1'b1;
            end
            OP_AND:  r_lo = A & B;
            OP_OR:   r_lo = A | B;
            OP_NAND: r_lo = ~(A & B);
            OP_NOR:  r_lo = ~(A | B);
            default: r_lo = '0;
         endcase
      end else if ((state == ST_BUSY) && eng_done) begin
         load  = 1'b1;
         r_lo  = eng_lo;
         r_hi  = eng_hi;
         r_ovf = mul_q && (eng_hi != '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_q   <= 1'b0;
         Alu_out <= '0;
         Alu_hi  <= '0;
         carry   <= 1'b0;
         zero    <= 1'b0;
         ovf     <= 1'b0;
         div0    <= 1'b0;
      end else begin
         if (accept) begin
            mul_q <= (Alu_sel == OP_MUL);
         end
         if (load) begin
            Alu_out <= r_lo;
            Alu_hi  <= r_hi;
            carry   <= r_carry;
            zero    <= (r_lo == '0);
            ovf     <= r_ovf;
            div0    <= r_div0;
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// ----------------------------------------------------------------------------
// tb_alu_seq
// Scoreboard bench for alu_seq (WIDTH=8). The driver pushes the expected
// response on each accept; a monitor on the falling edge compares every cycle
// that out_valid is high and pops when the result is consumed.
// ----------------------------------------------------------------------------
module tb_alu_seq;
   import alu_pkg::*;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic [2:0]   Alu_sel = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] Alu_out;
   logic [W-1:0] Alu_hi;
   logic         carry, zero, ovf, div0;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Alu_sel   (Alu_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Alu_out   (Alu_out),
      .Alu_hi    (Alu_hi),
      .carry     (carry),
      .zero      (zero),
      .ovf       (ovf),
      .div0      (div0)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic         carry;
      logic         zero;
      logic         ovf;
      logic         div0;
      int           lat;
      int           acc_cyc;
   } exp_t;

   exp_t sb[$];

   int rdy_mode = 0;       // 0 random, 1 held low, 2 held high
   int last_acc_cyc = 0;
   int last_pop_cyc = 0;
   bit seen = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model from the arithmetic definition of each opcode.
   function automatic exp_t model(input logic [2:0] op, input int a, input int b);
      exp_t e;
      int m = 1 << W;
      int r = 0, h = 0, p;
      e.carry = 1'b0; e.ovf = 1'b0; e.div0 = 1'b0; e.lat = 1; e.acc_cyc = 0;
      case (op)
         OP_ADD: begin r = a + b; e.carry = (r >= m); r = r % m; end
         OP_SUB: begin e.carry = (a < b); r = (a - b + m) % m; end
         OP_MUL: begin p = a * b; r = p % m; h = p / m; e.ovf = (h != 0); e.lat = W + 1; end
         OP_DIV: begin
            if (b == 0) begin r = 0; h = a; e.div0 = 1'b1; end
            else begin r = a / b; h = a % b; e.lat = W + 1; end
         end
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_NAND: r = (m - 1) - (a & b);
         default: r = (m - 1) - (a | b);
      endcase
      e.lo = r[W-1:0];
      e.hi = h[W-1:0];
      e.zero = (r == 0);
      return e;
   endfunction

   // out_ready generator
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         1:       out_ready = 1'b0;
         2:       out_ready = 1'b1;
         default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
   end

   // Monitor: compare whenever a result is presented, pop on consumption.
   always @(negedge clk) begin
      if (!rst_n) begin
         seen = 1'b0;
      end else if (out_valid) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL spurious_out_valid: got out_valid=1, expected no result pending (cycle %0d)", cyc);
         end else begin
            if (!seen) begin
               check("latency", cyc - sb[0].acc_cyc, sb[0].lat);
               seen = 1'b1;
            end
            check("Alu_out", Alu_out, sb[0].lo);
            check("Alu_hi", Alu_hi, sb[0].hi);
            check("carry", carry, sb[0].carry);
            check("zero", zero, sb[0].zero);
            check("ovf", ovf, sb[0].ovf);
            check("div0", div0, sb[0].div0);
            check("in_ready_in_done", in_ready, 0);
            if (out_ready) begin
               void'(sb.pop_front());
               seen = 1'b0;
               last_pop_cyc = cyc;
            end
         end
      end
   end

   // Present one op and hold it until accepted; scramble inputs afterwards.
   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      int waited = 0;
      bit ok = 1'b0;
      @(posedge clk); #1;
      A = a; B = b; Alu_sel = op; in_valid = 1'b1;
      while (!ok) begin
         @(negedge clk);
         if (in_ready) begin
            e = model(op, int'(a), int'(b));
            e.acc_cyc = cyc;
            last_acc_cyc = cyc;
            sb.push_back(e);
            ok = 1'b1;
         end else begin
            waited++;
            if (waited > 200) begin
               vectors++;
               miscompares++;
               $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected accept", waited);
               break;
            end
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      A = W'($urandom); B = W'($urandom); Alu_sel = 3'($urandom);
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("scoreboard_drained", sb.size(), 0);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return W'(1);
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      logic [2:0]   op;
      logic [W-1:0] a, b;

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_Alu_out", Alu_out, 0);
      check("rst_Alu_hi", Alu_hi, 0);
      check("rst_flags", {carry, zero, ovf, div0}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);

      // Directed cases
      issue(OP_ADD, 8'd200, 8'd100);
      issue(OP_SUB, 8'd5, 8'd9);
      issue(OP_SUB, 8'd9, 8'd9);
      issue(OP_MUL, 8'd20, 8'd20);
      issue(OP_MUL, 8'd15, 8'd17);
      issue(OP_DIV, 8'd100, 8'd7);
      issue(OP_DIV, 8'd5, 8'd0);
      issue(OP_AND, 8'hF0, 8'h3C);
      issue(OP_OR, 8'hA0, 8'h05);
      issue(OP_NAND, 8'hFF, 8'hFF);
      issue(OP_NOR, 8'h00, 8'h00);
      issue(OP_MUL, 8'hFF, 8'hFF);
      issue(OP_DIV, 8'hFF, 8'd1);
      drain();

      // Backpressure: result held 5 cycles, a waiting op must not sneak in.
      rdy_mode = 1;
      @(posedge clk); #2;
      issue(OP_MUL, 8'd20, 8'd20);
      fork
         begin
            int t = 0;
            while (!out_valid && t < 50) begin
               @(negedge clk);
               t++;
            end
            repeat (5) @(negedge clk);
            rdy_mode = 2;
         end
         issue(OP_ADD, 8'd3, 8'd4);
      join
      check("accept_after_release", last_acc_cyc - last_pop_cyc, 1);
      drain();
      rdy_mode = 0;

      // Reset three cycles into a divide: no result must ever appear.
      issue(OP_ADD, 8'd200, 8'd100);
      drain();
      issue(OP_DIV, 8'd100, 8'd7);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      sb.delete();
      #1;
      check("abort_out_valid", out_valid, 0);
      check("abort_Alu_out", Alu_out, 0);
      check("abort_Alu_hi", Alu_hi, 0);
      check("abort_flags", {carry, zero, ovf, div0}, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (W + 3) begin
         @(negedge clk);
         check("abort_no_result", out_valid, 0);
      end
      check("abort_in_ready", in_ready, 1);
      issue(OP_ADD, 8'd1, 8'd1);
      drain();

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         op = 3'($urandom);
         a  = pick();
         b  = ($urandom_range(0, 7) == 0) ? '0 : pick();
         issue(op, a, b);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 4)) @(posedge clk);
         end
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
